// File: rtl/syn_sys_mem_pkg.sv
// Shared definitions for the system-memory responder and its bench agent.
// Holds the default bus widths and the read-return token carried down the
// read delay line.
package syn_sys_mem_pkg;

  localparam int unsigned SYS_MEM_DATA_W = 32;
  localparam int unsigned SYS_MEM_ADDR_W = 27;

  // One slot of the read-return pipeline: qualifier plus data word.
  typedef struct packed {
    logic                      valid;
    logic [SYS_MEM_DATA_W-1:0] data;
  } sys_mem_rd_tok_t;

endpackage

// File: rtl/syn_sys_mem_ram.sv
// Single-port synchronous RAM with a registered read port.
// Ports:
//   clk, rst : clock and synchronous active-high reset (read register only)
//   we, re   : write / read enables (never both in one cycle)
//   addr     : word address
//   wdata    : write data
//   rdata    : registered read data, holds its value when re is low
module syn_sys_mem_ram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array; deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Registered read; only updated by a read so the value holds otherwise.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/syn_sys_mem_resp.sv
// On-chip-RAM responder for the system-memory controller interface.
// Reads return after a fixed RD_LAT cycles, in order, with at most MAX_OUTST
// reads in flight; stall_en forces back-pressure from the next cycle.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   mem_wait      : back-pressure, request accepted only while low
//   mem_wren/rden : write / read request
//   mem_addr      : word address (low MEM_ADDR_W bits index the RAM)
//   mem_wdata     : write data
//   mem_rd_valid  : one-cycle strobe qualifying mem_rdata
//   mem_rdata     : read data, holds last value between strobes
//   stall_en      : force mem_wait high from the next cycle
//   err_rdwr      : pulse, write and read accepted together (read dropped)
//   err_oor       : pulse, accepted address had bits above MEM_ADDR_W
module syn_sys_mem_resp #(
  parameter int unsigned SYS_MEM_DATA_W = syn_sys_mem_pkg::SYS_MEM_DATA_W,
  parameter int unsigned SYS_MEM_ADDR_W = syn_sys_mem_pkg::SYS_MEM_ADDR_W,
  parameter int unsigned MEM_ADDR_W     = 10,
  parameter int unsigned RD_LAT         = 3,
  parameter int unsigned MAX_OUTST      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      mem_wait,
  input  logic                      mem_wren,
  input  logic                      mem_rden,
  input  logic [SYS_MEM_ADDR_W-1:0] mem_addr,
  input  logic [SYS_MEM_DATA_W-1:0] mem_wdata,
  output logic                      mem_rd_valid,
  output logic [SYS_MEM_DATA_W-1:0] mem_rdata,
  input  logic                      stall_en,
  output logic                      err_rdwr,
  output logic                      err_oor
);

  import syn_sys_mem_pkg::*;

  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

  logic                      acc_c;
  logic                      wr_acc_c;
  logic                      rd_acc_c;
  logic                      oor_c;
  logic                      full_c;
  logic                      stall_q;
  logic                      v0_q;
  logic [CNT_W-1:0]          outst_cnt;
  logic [SYS_MEM_DATA_W-1:0] ram_rdata;
  sys_mem_rd_tok_t           head_c;
  sys_mem_rd_tok_t           tail_c;

  // Accept decode; a combined wren+rden performs only the write.
  assign acc_c    = (mem_wren | mem_rden) & ~mem_wait;
  assign wr_acc_c = acc_c & mem_wren;
  assign rd_acc_c = acc_c & mem_rden & ~mem_wren;
  assign oor_c    = |(mem_addr >> MEM_ADDR_W);

  // A read showing on the output this cycle no longer occupies a slot, so
  // mem_wait drops in the same cycle as its rd_valid.
  assign full_c   = (outst_cnt - CNT_W'(tail_c.valid)) == CNT_W'(MAX_OUTST);
  assign mem_wait = stall_q | full_c | rst;

  syn_sys_mem_ram #(
    .ADDR_W (MEM_ADDR_W),
    .DATA_W (SYS_MEM_DATA_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc_c),
    .re    (rd_acc_c),
    .addr  (mem_addr[MEM_ADDR_W-1:0]),
    .wdata (mem_wdata),
    .rdata (ram_rdata)
  );

  // First pipeline stage is the RAM read register plus its valid flag.
  assign head_c.valid = v0_q;
  assign head_c.data  = ram_rdata;

  // Remaining RD_LAT-1 stages; data only moves with a valid token so the
  // output word holds between strobes.
  if (RD_LAT == 1) begin : g_lat1
    assign tail_c = head_c;
  end else begin : g_line
    sys_mem_rd_tok_t line_q [RD_LAT-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < RD_LAT - 1; i++) line_q[i] <= '0;
      end else begin
        line_q[0].valid <= head_c.valid;
        if (head_c.valid) line_q[0].data <= head_c.data;
        for (int unsigned i = 1; i < RD_LAT - 1; i++) begin
          line_q[i].valid <= line_q[i-1].valid;
          if (line_q[i-1].valid) line_q[i].data <= line_q[i-1].data;
        end
      end
    end

    assign tail_c = line_q[RD_LAT-2];
  end

  assign mem_rd_valid = tail_c.valid;
  assign mem_rdata    = tail_c.data;

  // Control registers: stall, first-stage valid, outstanding count, errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q   <= 1'b0;
      v0_q      <= 1'b0;
      outst_cnt <= '0;
      err_rdwr  <= 1'b0;
      err_oor   <= 1'b0;
    end else begin
      stall_q  <= stall_en;
      v0_q     <= rd_acc_c;
      err_rdwr <= acc_c & mem_wren & mem_rden;
      err_oor  <= acc_c & oor_c;
      case ({rd_acc_c, tail_c.valid})
        2'b10:   outst_cnt <= outst_cnt + CNT_W'(1);
        2'b01:   outst_cnt <= outst_cnt - CNT_W'(1);
        default: outst_cnt <= outst_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_syn_sys_mem_resp.sv
// Self-checking bench for syn_sys_mem_resp: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a transaction-level
// model (word array plus a queue of reads tagged with their return cycle).
module tb_syn_sys_mem_resp;

  localparam int RD_LAT    = 3;
  localparam int MAX_OUTST = 2;

  typedef struct {
    int          due;
    logic [31:0] data;
  } pend_t;

  logic        clk;
  logic        rst;
  logic        mem_wait;
  logic        mem_wren;
  logic        mem_rden;
  logic [26:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd_valid;
  logic [31:0] mem_rdata;
  logic        stall_en;
  logic        err_rdwr;
  logic        err_oor;

  syn_sys_mem_resp #(
    .SYS_MEM_DATA_W (32),
    .SYS_MEM_ADDR_W (27),
    .MEM_ADDR_W     (10),
    .RD_LAT         (RD_LAT),
    .MAX_OUTST      (MAX_OUTST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_wait     (mem_wait),
    .mem_wren     (mem_wren),
    .mem_rden     (mem_rden),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rd_valid (mem_rd_valid),
    .mem_rdata    (mem_rdata),
    .stall_en     (stall_en),
    .err_rdwr     (err_rdwr),
    .err_oor      (err_oor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mem_m [1024];
  pend_t       q[$];
  logic        stall_m;
  logic        stall_drv;
  logic        last_acc;
  logic        exp_rv;
  logic [31:0] exp_rdata;
  logic        exp_err_rdwr;
  logic        exp_err_oor;
  int          cyc;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check mem_wait, advance model, check outputs.
  task automatic step(input logic r, input logic w, input logic rd,
                      input logic [26:0] a, input logic [31:0] d);
    logic  exp_wait;
    pend_t p;
    @(negedge clk);
    rst       = r;
    mem_wren  = w;
    mem_rden  = rd;
    mem_addr  = a;
    mem_wdata = d;
    stall_en  = stall_drv;
    #1;
    exp_wait = r | stall_m | (q.size() == MAX_OUTST);
    chk("mem_wait", 32'(mem_wait), 32'(exp_wait));
    last_acc = (w | rd) & ~exp_wait;
    @(posedge clk);
    cyc++;
    exp_rv       = 1'b0;
    exp_err_rdwr = 1'b0;
    exp_err_oor  = 1'b0;
    if (r) begin
      q.delete();
      stall_m   = 1'b0;
      exp_rdata = '0;
    end else begin
      if (last_acc && w) begin
        mem_m[a[9:0]] = d;
      end else if (last_acc && rd) begin
        p.due  = cyc + RD_LAT - 1;
        p.data = mem_m[a[9:0]];
        q.push_back(p);
      end
      exp_err_rdwr = last_acc & w & rd;
      exp_err_oor  = last_acc & (a[26:10] != 17'd0);
      stall_m      = stall_drv;
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_rv    = 1'b1;
        exp_rdata = q[0].data;
        void'(q.pop_front());
      end
    end
    #1;
    chk("rd_valid", 32'(mem_rd_valid), 32'(exp_rv));
    chk("rdata",    mem_rdata,         exp_rdata);
    chk("err_rdwr", 32'(err_rdwr),     32'(exp_err_rdwr));
    chk("err_oor",  32'(err_oor),      32'(exp_err_oor));
  endtask

  // Present a request and hold it until the model says it was accepted.
  task automatic req(input logic w, input logic rd, input logic [26:0] a, input logic [31:0] d);
    int n;
    n = 0;
    do begin
      step(1'b0, w, rd, a, d);
      n++;
    end while (!last_acc && n < 64);
    if (!last_acc) begin
      errors++;
      $error("FAIL req_timeout observed=not_accepted expected=accepted addr=%0h", a);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 27'd0, 32'd0);
  endtask

  initial begin
    logic        cw;
    logic        crd;
    logic [26:0] ca;
    logic [31:0] cd;
    int          k;

    checks    = 0;
    errors    = 0;
    cyc       = 0;
    stall_m   = 1'b0;
    stall_drv = 1'b0;
    last_acc  = 1'b0;
    exp_rdata = '0;
    rst       = 1'b1;
    mem_wren  = 1'b0;
    mem_rden  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    stall_en  = 1'b0;

    // Reset, then give every word used below a known value.
    step(1'b1, 1'b0, 1'b0, 27'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 27'd0, 32'd0);
    for (int i = 0; i < 64; i++) req(1'b1, 1'b0, 27'(i), $urandom);
    idle(1);

    // Write then read back.
    req(1'b1, 1'b0, 27'h10, 32'hA5A5_0001);
    req(1'b0, 1'b1, 27'h10, 32'd0);
    idle(4);

    // Back-to-back reads, held by back-pressure when the window fills.
    for (int i = 0; i < 4; i++) req(1'b0, 1'b1, 27'(i), 32'd0);
    idle(5);

    // Forced stall with a pending write, then readback.
    stall_drv = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 27'h05, 32'hCAFE_0005);
    stall_drv = 1'b0;
    req(1'b1, 1'b0, 27'h05, 32'hCAFE_0005);
    req(1'b0, 1'b1, 27'h05, 32'd0);
    idle(4);

    // Combined write+read: write lands, read dropped.
    req(1'b1, 1'b1, 27'h20, 32'h0000_1234);
    idle(4);
    req(1'b0, 1'b1, 27'h20, 32'd0);
    idle(4);

    // Out-of-range address aliases onto word 0.
    req(1'b1, 1'b0, 27'h400, 32'hDEAD_0400);
    req(1'b0, 1'b1, 27'h000, 32'd0);
    req(1'b0, 1'b1, 27'h400, 32'd0);
    idle(5);

    // Reset with two reads in flight; RAM must survive.
    req(1'b0, 1'b1, 27'h10, 32'd0);
    req(1'b0, 1'b1, 27'h11, 32'd0);
    step(1'b1, 1'b0, 1'b0, 27'd0, 32'd0);
    idle(5);
    req(1'b0, 1'b1, 27'h10, 32'd0);
    req(1'b0, 1'b1, 27'h05, 32'd0);
    idle(4);

    // Randomized traffic; requests are held until accepted.
    cw  = 1'b0;
    crd = 1'b0;
    ca  = '0;
    cd  = '0;
    for (int i = 0; i < 500; i++) begin
      if (!(cw | crd) || last_acc) begin
        k   = int'($urandom_range(0, 9));
        cw  = (k >= 3 && k <= 5) || (k == 9);
        crd = (k >= 6);
        ca  = {(($urandom_range(0, 7) == 0) ? 17'($urandom) : 17'd0),
               10'($urandom_range(0, 63))};
        cd  = $urandom;
      end
      if ($urandom_range(0, 9) == 0) stall_drv = ~stall_drv;
      if ($urandom_range(0, 149) == 0) begin
        stall_drv = 1'b0;
        step(1'b1, cw, crd, ca, cd);
      end else begin
        step(1'b0, cw, crd, ca, cd);
      end
    end
    stall_drv = 1'b0;
    idle(RD_LAT + 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
